// File: rtl/pe_array_input_skewer.sv
// rtl/pe_array_input_skewer.sv - skews packed activation vectors into a diagonal wavefront for the PE array
module pe_array_input_skewer #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   adv_en,
    output logic [ROWS*DATA_W-1:0] iact_out,
    output logic [ROWS-1:0]        lane_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               xfer;

    assign in_ready = adv_en && (state_q == S_IDLE || state_q == S_STREAM);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (adv_en) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE, S_STREAM: begin
                    if (xfer) begin
                        if (in_last) begin
                            if (ROWS == 1) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_FLUSH;
                                cnt_d   = CNT_W'(ROWS - 1);
                            end
                        end else begin
                            state_d = S_STREAM;
                        end
                    end
                end
                S_FLUSH: begin
                    // Counter hits zero on the edge that moves the last element into lane ROWS-1.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_lane
        logic [DATA_W-1:0] dat_q [0:i];
        logic [DATA_W-1:0] dat_d [0:i];
        logic [i:0]        vld_q, vld_d;

        always_comb begin
            vld_d = vld_q;
            for (int j = 0; j <= i; j++) begin
                dat_d[j] = dat_q[j];
            end
            if (adv_en) begin
                // Bubbles and flush cycles load zero so downstream PEs leave psum untouched.
                dat_d[0] = xfer ? in_data[i*DATA_W +: DATA_W] : '0;
                vld_d[0] = xfer;
                for (int j = 1; j <= i; j++) begin
                    dat_d[j] = dat_q[j-1];
                    vld_d[j] = vld_q[j-1];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int j = 0; j <= i; j++) begin
                    dat_q[j] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                for (int j = 0; j <= i; j++) begin
                    dat_q[j] <= dat_d[j];
                end
            end
        end

        assign iact_out[i*DATA_W +: DATA_W] = dat_q[i];
        assign lane_valid[i]                = vld_q[i];
    end

endmodule

// File: tb/tb_pe_array_input_skewer.sv
// tb/tb_pe_array_input_skewer.sv - directed bench for pe_array_input_skewer
module tb_pe_array_input_skewer;

    localparam int ROWS   = 4;
    localparam int DATA_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [ROWS*DATA_W-1:0] in_data;
    logic                   adv_en;
    logic [ROWS*DATA_W-1:0] iact_out;
    logic [ROWS-1:0]        lane_valid;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_array_input_skewer #(.ROWS(ROWS), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .adv_en     (adv_en),
        .iact_out   (iact_out),
        .lane_valid (lane_valid),
        .busy       (busy),
        .done       (done)
    );

    function automatic logic [63:0] pack(input int l0, input int l1, input int l2, input int l3);
        logic [31:0] a, b, c, d;
        a = l0; b = l1; c = l2; d = l3;
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic send(input logic [63:0] v, input logic last);
        in_valid = 1'b1;
        in_last  = last;
        in_data  = v;
    endtask

    initial begin
        rst    = 1'b1;
        adv_en = 1'b1;
        idle_in();
        #12;
        chk("rst_iact", iact_out, 64'h0);
        chk("rst_lv", 64'(lane_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        step();
        rst = 1'b0;

        // single vector with last
        send(pack(1, 2, 3, 4), 1'b1);
        step(); idle_in();
        chk("t1_e0_iact", iact_out, pack(1, 0, 0, 0));
        chk("t1_e0_lv", 64'(lane_valid), 64'b0001);
        chk("t1_e0_ready", 64'(in_ready), 64'h0);
        chk("t1_e0_busy", 64'(busy), 64'h1);
        step();
        chk("t1_e1_iact", iact_out, pack(0, 2, 0, 0));
        chk("t1_e1_lv", 64'(lane_valid), 64'b0010);
        chk("t1_e1_ready", 64'(in_ready), 64'h0);
        step();
        chk("t1_e2_iact", iact_out, pack(0, 0, 3, 0));
        chk("t1_e2_ready", 64'(in_ready), 64'h0);
        chk("t1_e2_done", 64'(done), 64'h0);
        step();
        chk("t1_e3_iact", iact_out, pack(0, 0, 0, 4));
        chk("t1_e3_lv", 64'(lane_valid), 64'b1000);
        chk("t1_e3_done", 64'(done), 64'h1);
        chk("t1_e3_ready", 64'(in_ready), 64'h1);
        chk("t1_e3_busy", 64'(busy), 64'h0);
        step();
        chk("t1_e4_done", 64'(done), 64'h0);
        chk("t1_e4_iact", iact_out, 64'h0);

        // three back-to-back vectors
        send(pack(10, 20, 30, 40), 1'b0);
        step();
        send(pack(-1, -2, -3, -4), 1'b0);
        step();
        send(pack(5, 6, 7, 8), 1'b1);
        step(); idle_in();
        chk("t2_e2_iact", iact_out, pack(5, -2, 30, 0));
        chk("t2_e2_lv", 64'(lane_valid), 64'b0111);
        step();
        chk("t2_e3_iact", iact_out, pack(0, 6, -3, 40));
        chk("t2_e3_ready", 64'(in_ready), 64'h0);
        step();
        chk("t2_e4_done", 64'(done), 64'h0);
        step();
        chk("t2_e5_iact", iact_out, pack(0, 0, 0, 8));
        chk("t2_e5_done", 64'(done), 64'h1);
        step();

        // bubble between vectors
        send(pack(1, 1, 1, 1), 1'b0);
        step(); idle_in();
        chk("t3_e0_l0", 64'(iact_out[15:0]), 64'd1);
        chk("t3_e0_v0", 64'(lane_valid[0]), 64'h1);
        step();
        send(pack(2, 2, 2, 2), 1'b1);
        chk("t3_e1_l0", 64'(iact_out[15:0]), 64'd0);
        chk("t3_e1_v0", 64'(lane_valid[0]), 64'h0);
        step(); idle_in();
        chk("t3_e2_l0", 64'(iact_out[15:0]), 64'd2);
        chk("t3_e2_v0", 64'(lane_valid[0]), 64'h1);
        step();
        chk("t3_e3_l3", 64'(iact_out[63:48]), 64'd1);
        chk("t3_e3_v3", 64'(lane_valid[3]), 64'h1);
        step();
        chk("t3_e4_v3", 64'(lane_valid[3]), 64'h0);
        chk("t3_e4_done", 64'(done), 64'h0);
        step();
        chk("t3_e5_l3", 64'(iact_out[63:48]), 64'd2);
        chk("t3_e5_done", 64'(done), 64'h1);
        step();

        // stall during flush
        send(pack(7, 7, 7, 7), 1'b1);
        step(); idle_in();
        step();
        chk("t4_e1_iact", iact_out, pack(0, 7, 0, 0));
        adv_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_stall_ready", 64'(in_ready), 64'h0);
            step();
            chk("t4_stall_iact", iact_out, pack(0, 7, 0, 0));
            chk("t4_stall_done", 64'(done), 64'h0);
            chk("t4_stall_busy", 64'(busy), 64'h1);
        end
        adv_en = 1'b1;
        step();
        chk("t4_e2_iact", iact_out, pack(0, 0, 7, 0));
        chk("t4_e2_done", 64'(done), 64'h0);
        step();
        chk("t4_e3_iact", iact_out, pack(0, 0, 0, 7));
        chk("t4_e3_done", 64'(done), 64'h1);
        adv_en = 1'b0;
        step();
        chk("t4_done_held", 64'(done), 64'h1);
        adv_en = 1'b1;
        step();
        chk("t4_done_clr", 64'(done), 64'h0);

        // asynchronous reset mid-stream
        send(pack(9, 9, 9, 9), 1'b0);
        step();
        send(pack(8, 8, 8, 8), 1'b0);
        step(); idle_in();
        chk("t5_pre_iact", iact_out, pack(8, 9, 0, 0));
        #3 rst = 1'b1;
        #1;
        chk("t5_rst_iact", iact_out, 64'h0);
        chk("t5_rst_lv", 64'(lane_valid), 64'h0);
        chk("t5_rst_busy", 64'(busy), 64'h0);
        #2 rst = 1'b0;
        send(pack(1, 2, 3, 4), 1'b1);
        step(); idle_in();
        chk("t5_e0_iact", iact_out, pack(1, 0, 0, 0));
        chk("t5_e0_lv", 64'(lane_valid), 64'b0001);
        step();
        chk("t5_e1_iact", iact_out, pack(0, 2, 0, 0));
        step();
        chk("t5_e2_iact", iact_out, pack(0, 0, 3, 0));
        step();
        chk("t5_e3_iact", iact_out, pack(0, 0, 0, 4));
        chk("t5_e3_done", 64'(done), 64'h1);
        step();

        // signed extremes
        send(pack(32767, -32768, -1, 0), 1'b1);
        step(); idle_in();
        chk("t6_e0_l0", 64'(iact_out[15:0]), 64'h7fff);
        step();
        chk("t6_e1_l1", 64'(iact_out[31:16]), 64'h8000);
        step();
        chk("t6_e2_l2", 64'(iact_out[47:32]), 64'hffff);
        chk("t6_e2_lv", 64'(lane_valid), 64'b0100);
        step();
        chk("t6_e3_iact", iact_out, 64'h0);
        chk("t6_e3_lv", 64'(lane_valid), 64'b1000);
        chk("t6_e3_done", 64'(done), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
